// File: rtl/des_key_schedule.sv
// DES round-key generator and 16-round sequencer: emits K1..K16 (or K16..K1)
// together with the mux/load controls for the downstream round datapath.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] key,
  input  logic        decrypt,
  input  logic        start,
  output logic [0:47] round_key,
  output logic        mux,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic [3:0]  round
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // FIPS 46-3 tables, 1-based bit numbers (bit 1 = MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [0:55] pc1_perm(input logic [0:63] k);
    logic [0:55] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[i] = k[PC1[i] - 1];
    return r;
  endfunction

  function automatic logic [0:47] pc2_perm(input logic [0:55] cd);
    logic [0:47] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[i] = cd[PC2[i] - 1];
    return r;
  endfunction

  function automatic logic [0:27] rotl(input logic [0:27] v, input logic two);
    return two ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

  function automatic logic [0:27] rotr(input logic [0:27] v, input logic two);
    return two ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction

  state_t      state_q;
  logic [0:27] c_q, d_q;
  logic [0:27] c_d, d_d;
  logic [3:0]  cnt_q;
  logic        dec_q;
  logic        mux_q, load_q, busy_q, done_q;
  logic [3:0]  round_q;
  logic [0:55] pc1_key;
  logic        one_shift;

  // Encrypt and decrypt step by a single position at the same counter values.
  always_comb begin
    pc1_key   = pc1_perm(key);
    one_shift = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);
    c_d       = c_q;
    d_d       = d_q;
    if (state_q != RUN) begin
      if (start) begin
        c_d = decrypt ? pc1_key[0:27]  : rotl(pc1_key[0:27], 1'b0);
        d_d = decrypt ? pc1_key[28:55] : rotl(pc1_key[28:55], 1'b0);
      end
    end else if (cnt_q != 4'd15) begin
      c_d = dec_q ? rotr(c_q, !one_shift) : rotl(c_q, !one_shift);
      d_d = dec_q ? rotr(d_q, !one_shift) : rotl(d_q, !one_shift);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      mux_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      round_q <= '0;
    end else begin
      c_q <= c_d;
      d_q <= d_d;
      case (state_q)
        RUN: begin
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
            mux_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            round_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 4'd1;
            mux_q   <= 1'b1;
            round_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            dec_q   <= decrypt;
            mux_q   <= 1'b0;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            round_q <= '0;
          end else begin
            state_q <= IDLE;
            mux_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            round_q <= '0;
          end
        end
      endcase
    end
  end

  assign round_key = pc2_perm({c_q, d_q});
  assign mux       = mux_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign round     = round_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus queues expected round keys,
// a negedge monitor pops and compares whenever load or done is presented.
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic [63:0] key;
  logic        decrypt;
  logic        start;
  logic [47:0] round_key;
  logic        mux, load, busy, done;
  logic [3:0]  round;

  des_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .decrypt   (decrypt),
    .start     (start),
    .round_key (round_key),
    .mux       (mux),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .round     (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] K  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KP = 64'h123556789ABDDEF0;  // K with every parity bit flipped

  // Round keys K1..K16 for K, worked by hand from PC-1/PC-2 and the shift table.
  localparam logic [47:0] EK [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [47:0] rk;
    logic        mx;
    logic [3:0]  rnd;
    logic        dn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (load || done)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: load=%0b done=%0b expected no activity", load, done);
      end else begin
        e = q.pop_front();
        if (e.dn) begin
          chk("done_pulse", 64'(done), 64'd1);
          chk("load_in_done", 64'(load), 64'd0);
          chk("round_in_done", 64'(round), 64'd0);
        end else begin
          chk("load_in_run", 64'(load), 64'd1);
          chk("done_in_run", 64'(done), 64'd0);
          chk("busy_in_run", 64'(busy), 64'd1);
          chk("round_key", 64'(round_key), 64'(e.rk));
          chk("mux", 64'(mux), 64'(e.mx));
          chk("round", 64'(round), 64'(e.rnd));
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge with round 1 on the outputs.
  task automatic issue(input logic [63:0] k, input logic dec);
    exp_t e;
    key     = k;
    decrypt = dec;
    start   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e.rk  = dec ? EK[15 - i] : EK[i];
      e.mx  = (i != 0);
      e.rnd = 4'(i);
      e.dn  = 1'b0;
      q.push_back(e);
    end
    e    = '0;
    e.dn = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_load"}, 64'(load), 64'd0);
    chk({tag, "_mux"}, 64'(mux), 64'd0);
    chk({tag, "_round"}, 64'(round), 64'd0);
    chk({tag, "_round_key"}, 64'(round_key), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    key     = '0;
    decrypt = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Encrypt with latency checks: round 16 at N16, done at N17, idle after.
    issue(K, 1'b0);
    repeat (15) @(negedge clk);
    chk("load_round16", 64'(load), 64'd1);
    chk("done_round16", 64'(done), 64'd0);
    @(negedge clk);
    chk("done_latency17", 64'(done), 64'd1);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_after_done", 64'(done), 64'd0);
    wait_drain();

    // Decrypt: reverse order.
    issue(K, 1'b1);
    wait_drain();

    // Start re-pulsed at round 5 with a different key/mode: must be ignored.
    issue(K, 1'b0);
    repeat (4) @(negedge clk);
    chk("round5_index", 64'(round), 64'd4);
    key     = 64'hFFFF_0000_A5A5_5A5A;
    decrypt = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Start in the DONE cycle: next run begins with no idle gap.
    issue(K, 1'b0);
    repeat (16) @(negedge clk);
    chk("done_before_restart", 64'(done), 64'd1);
    issue(K, 1'b1);
    chk("restart_no_gap_load", 64'(load), 64'd1);
    chk("restart_round0", 64'(round), 64'd0);
    wait_drain();

    // Asynchronous reset at round 9, then a clean full run.
    issue(K, 1'b0);
    repeat (8) @(negedge clk);
    chk("round9_index", 64'(round), 64'd8);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_reset");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(K, 1'b0);
    wait_drain();

    // Parity bits ignored: same sequences as K.
    issue(KP, 1'b0);
    wait_drain();
    issue(KP, 1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
